// File: rtl/phase_exec_pkg.sv
// phase_exec_pkg: shared widths, opcode and FSM state encodings for phase_exec.
package phase_exec_pkg;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 12;
    localparam int NREGS   = 4;
    localparam int IMM_W   = 5;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_SHL = 3'b111
    } op_e;

    // Encoding order matters: state N waits for phase strobe N+1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        EXE  = 2'd2,
        WB   = 2'd3
    } state_e;
endpackage

// File: rtl/phase_exec_if.sv
// phase_exec_if: phase strobes, instruction offer and writeback/status report.
interface phase_exec_if;
    import phase_exec_pkg::*;
    logic               ph1, ph2, ph3, ph4;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic               wb_valid;
    logic [1:0]         wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               zero, carry, phase_err;
    logic [7:0]         instr_count;

    modport master (
        output ph1, ph2, ph3, ph4, instr_valid, instr,
        input  instr_ready, wb_valid, wb_addr, wb_data, zero, carry, phase_err, instr_count
    );
    modport slave (
        input  ph1, ph2, ph3, ph4, instr_valid, instr,
        output instr_ready, wb_valid, wb_addr, wb_data, zero, carry, phase_err, instr_count
    );
endinterface

// File: rtl/phase_exec_alu.sv
// phase_exec_alu: combinational 8-bit ALU producing result, carry/borrow and zero.
module phase_exec_alu
    import phase_exec_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = {{(DATA_W - IMM_W){1'b0}}, imm};
            OP_SHL:  {carry, result} = {a, 1'b0};
            default: result = '0;
        endcase
    end
    assign zero = (result == '0);
endmodule

// File: rtl/phase_exec.sv
// phase_exec: four-phase sequenced register machine (fetch/decode/execute/writeback).
module phase_exec
    import phase_exec_pkg::*;
(
    input logic         clk,
    input logic         reset,
    phase_exec_if.slave bus
);
    logic [3:0]         ph;
    logic               one, hit, wrong, accept, advance, wb_go, fire;
    state_e             state, state_n;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [DATA_W-1:0]  a_q, b_q, res_q, alu_res, wb_data_q;
    logic [1:0]         wb_addr_q, rd, rs;
    logic               c_q, z_q, alu_c, alu_z, zero_q, carry_q, err_q;
    logic [7:0]         cnt_q;
    op_e                op;

    assign ph = {bus.ph4, bus.ph3, bus.ph2, bus.ph1};
    assign one = $onehot(ph);
    assign op = op_e'(ir[11:9]);
    assign rd = ir[8:7];
    assign rs = ir[6:5];

    // Outside IDLE a lone wrong strobe aborts; more than one strobe aborts anywhere.
    always_comb begin
        hit     = one && ph[state];
        wrong   = (ph != 4'b0 && !one) || (one && !ph[state] && state != IDLE);
        accept  = hit && state == IDLE && bus.instr_valid;
        advance = hit && (state != IDLE || bus.instr_valid);
        wb_go   = hit && state == WB;
        fire    = wb_go && op != OP_NOP;
        state_n = wrong ? IDLE : advance ? state_e'(state + 2'd1) : state;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    phase_exec_alu alu (
        .op(op), .a(a_q), .b(b_q), .imm(ir[4:0]),
        .result(alu_res), .carry(alu_c), .zero(alu_z)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            if (wrong) err_q <= 1'b1;
            if (accept) ir <= bus.instr;
            if (hit && state == DEC) begin
                a_q <= regs[rd];
                b_q <= regs[rs];
            end
            if (hit && state == EXE) begin
                res_q <= alu_res;
                c_q   <= alu_c;
                z_q   <= alu_z;
            end
            if (wb_go) cnt_q <= cnt_q + 8'd1;
            if (fire) begin
                regs[rd]  <= res_q;
                wb_addr_q <= rd;
                wb_data_q <= res_q;
                zero_q    <= z_q;
                carry_q   <= c_q;
            end
        end
    end

    assign bus.instr_ready = accept && !reset;
    assign bus.wb_valid    = fire;
    assign bus.wb_addr     = fire ? rd : wb_addr_q;
    assign bus.wb_data     = fire ? res_q : wb_data_q;
    assign bus.zero        = zero_q;
    assign bus.carry       = carry_q;
    assign bus.phase_err   = err_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: doc/phase_exec.md
PHASE_EXEC -- requirements
Module: phase_exec

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ph1, ph2, ph3, ph4  in  1 each  one-cycle phase strobes from the four-phase clock generator.
REQ-003 SHALL have instr_valid  in  1  and instr  in  12  instruction offered: op[11:9], rd[8:7], rs[6:5], imm[4:0].
REQ-004 SHALL have instr_ready  out  1  high when an instruction is accepted this cycle.
REQ-005 SHALL have wb_valid  out  1, wb_addr  out  2, wb_data  out  8  register writeback report.
REQ-006 SHALL have zero  out  1, carry  out  1  flags; phase_err  out  1  sticky sequence error; instr_count  out  8  retired instructions.

Function
REQ-007 SHALL implement FSM states IDLE, DEC, EXE, WB; each state waits for its phase: IDLE->ph1, DEC->ph2, EXE->ph3, WB->ph4.
REQ-008 SHALL, in IDLE, assert instr_ready combinationally iff ph1 && instr_valid, latch instr, and go to DEC; ph1 without valid stays IDLE.
REQ-009 SHALL, on ph2 in DEC, read rd and rs from a 4x8 register file into operand registers and go to EXE.
REQ-010 SHALL, on ph3 in EXE, compute result and next flags into pipeline registers and go to WB.
REQ-011 SHALL, on ph4 in WB, write result to rd, pulse wb_valid for exactly that cycle with wb_addr=rd, wb_data=result, update flags, increment instr_count (wraps 255->0), and return to IDLE.
REQ-012 SHALL decode ops: 000 NOP, 001 ADD rd+rs, 010 SUB rd-rs, 011 AND, 100 OR, 101 XOR, 110 LDI rd={3'b000,imm}, 111 SHL rd<<1.
REQ-013 SHALL compute carry: ADD = bit 8 of 9-bit sum; SUB = borrow (rd<rs); SHL = rd[7]; AND/OR/XOR/LDI = 0; zero = (result==8'h00).
REQ-014 SHALL treat NOP as a full four-phase pass: no register write, wb_valid=0, flags unchanged, instr_count incremented.
REQ-015 SHALL treat all-zero phase inputs as a stall cycle: no state change, no error.
REQ-016 SHALL, in DEC/EXE/WB, treat any single phase other than the expected one as an error: set phase_err, discard the in-flight instruction (no write, no count), go to IDLE.
REQ-017 SHALL, in any state, treat more than one phase high as an error: set phase_err, abort as REQ-016, and not accept an instruction that cycle.
REQ-018 SHALL ignore ph2/ph3/ph4 in IDLE without error.
REQ-019 SHALL keep phase_err set until reset; the block continues operating after an error.
REQ-020 SHALL keep wb_addr/wb_data holding their last value when wb_valid=0.

Reset
REQ-021 SHALL, on reset (any time, including mid-instruction), asynchronously force state=IDLE, all registers r0-r3=0, wb_valid=0, wb_addr=0, wb_data=0, zero=0, carry=0, phase_err=0, instr_count=0, and drop any in-flight instruction.
REQ-022 SHALL drive instr_ready=0 while reset is high.

Structure
REQ-023 SHALL place opcode enum, FSM state enum, DATA_W=8, INSTR_W=12, NREGS=4 in package phase_exec_pkg.
REQ-024 SHALL implement arithmetic in one combinational sub-module phase_exec_alu (op, a, b, imm -> result, carry, zero).

Verification
REQ-025 SHALL cover: reset, then LDI r1,5 with phases 1..4 -> instr_ready on ph1 cycle, wb_valid on ph4 cycle, wb_addr=1, wb_data=8'h05, zero=0, carry=0, instr_count=1.
REQ-026 SHALL cover: LDI r2,16 then SHL r2 x4 -> wb_data 32, 64, 128, then 0 with carry=1, zero=1.
REQ-027 SHALL cover: LDI r0,3; LDI r1,5; SUB r0,r1 -> wb_data=8'hFE, carry=1, zero=0; SUB r1,r1 -> 8'h00, zero=1, carry=0.
REQ-028 SHALL cover: accept on ph1, then ph3 instead of ph2 -> phase_err=1, no wb_valid, instr_count unchanged, next ph1 accepts a new instruction.
REQ-029 SHALL cover: ph1 and ph2 high together in IDLE with instr_valid=1 -> instr_ready=0, phase_err=1; all-zero phase gaps between phases -> instruction completes normally.
REQ-030 SHALL cover: reset asserted in EXE after ADD accepted -> all outputs zero immediately, no wb_valid; subsequent reads show r0-r3=0.
